mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single main-memory port between the instruction cache (line reads only) and the
//  data cache (line reads, dirty-line writebacks, or a writeback followed by a fill).
//  Sits between both caches and main memory. Grants one transaction at a time and
//  sequences a D-side writeback before its refill. Routes each response to its requester.
// PARAMETERS
//  LINE_W   128  cache line width in bits
//  LADDR_W  28   line address width (byte address [31:4])
//  TO_MAX   255  cycles to wait for mem_ack before asserting mem_timeout
// PORTS
//  clk              in   1        clock, posedge
//  reset            in   1        synchronous, active-high
//  reqI_mem         in   1        I-cache line read request, level, held until read_ready_I
//  reqAddrI_mem     in   LADDR_W  I-cache line address
//  reqD_mem         in   1        D-cache request, level, held until done
//  reqD_cache_write in   1        D request carries a writeback of data_to_mem first
//  reqD_fill        in   1        D request also needs a refill (0 = writeback only)
//  reqAddrD_mem     in   LADDR_W  D refill line address
//  reqAddrD_write_mem in LADDR_W  D writeback line address
//  data_to_mem      in   LINE_W   D writeback data
//  data_from_mem_I  out  LINE_W   fill data for I-cache, valid with read_ready_I
//  read_ready_I     out  1        1-cycle pulse: I fill complete
//  data_from_mem_D  out  LINE_W   fill data for D-cache, valid with read_ready_from_mem
//  read_ready_from_mem out 1      1-cycle pulse: D fill complete
//  written_data_ack out  1        1-cycle pulse: D writeback accepted (writeback-only requests)
//  mem_req          out  1        memory request, held until mem_ack
//  mem_we           out  1        1 = line write, 0 = line read
//  mem_addr         out  LADDR_W  memory line address
//  mem_wdata        out  LINE_W   memory write data
//  mem_rdata        in   LINE_W   memory read data, valid with mem_ack
//  mem_ack          in   1        1-cycle pulse completing the current mem_req
//  mem_timeout      out  1        sticky error: no mem_ack within TO_MAX cycles
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0. last_grant = I, so D wins first contention. Counter cleared.
//  Reset mid-transaction abandons the transaction; no ack is issued. The caches also reset.
//  States: IDLE, WB, FILL_D, FILL_I, RESP.
//  IDLE: if both requests are pending, the side not in last_grant wins (round-robin). Otherwise the single requester wins.
//    D grant with reqD_cache_write=1 -> WB. D grant without writeback -> FILL_D. I grant -> FILL_I.
//    Request inputs, addresses and data_to_mem are registered at grant. Later input changes are ignored.
//  WB: mem_req=1, mem_we=1, mem_addr=latched write address, mem_wdata=latched line.
//    On mem_ack: if latched reqD_fill -> FILL_D; else pulse written_data_ack -> RESP.
//  FILL_D / FILL_I: mem_req=1, mem_we=0, mem_addr=latched fill address.
//    On mem_ack: register mem_rdata into data_from_mem_D/I. Pulse read_ready_from_mem/read_ready_I. -> RESP.
//  RESP: exactly one cycle, lets the requester drop its level request. Then -> IDLE, last_grant updated.
//    A request still high in IDLE is treated as new.
//  mem_req drops in the cycle after mem_ack. It never re-asserts before RESP completes.
//  Minimum occupancy: grant cycle + 1 memory cycle + RESP. WB+fill uses two memory transactions, no gap.
//  data_from_mem_* hold their value until the next fill to the same side.
//  Timeout: a counter runs while mem_req=1 and clears on mem_ack. At TO_MAX, mem_timeout sets (sticky until reset).
//    The state does not change; the arbiter keeps waiting.
//  mem_ack outside WB/FILL states is ignored.
//  The pulse outputs never assert simultaneously.
// STRUCTURE
//  mem_pkg: typedef enum arb_state_t {IDLE,WB,FILL_D,FILL_I,RESP}; LINE_W/LADDR_W localparams;
//    typedef enum {GNT_I,GNT_D} grant_t.
//  Sub-module rr_arb2 (2-input round-robin, combinational grant + registered last_grant), used in IDLE.
//  Remaining logic is one FSM plus latch registers in this module.
// TESTING
//  I-only read 0x0000040, mem_ack 3 cycles after mem_req -> mem_we=0 and mem_addr=0x0000040.
//    read_ready_I pulses 1 cycle after ack with mem_rdata.
//  D writeback+fill (wr 0x1230, fill 0x4560) -> WB with mem_wdata=data_to_mem, then FILL_D at 0x4560.
//    Single read_ready_from_mem pulse. No written_data_ack.
//  D writeback-only -> one write transaction. written_data_ack pulses once. No fill pulse.
//  reqI and reqD both high after reset -> D served first. When both stay high, I served next and grants alternate I,D,I,D.
//  Hold mem_ack low for TO_MAX cycles -> mem_timeout=1 at cycle TO_MAX. A later ack completes normally and mem_timeout stays 1.
//  Assert reset during FILL_D -> next cycle mem_req=0, no ready pulse. After release, a fresh I request is granted.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the cache-to-memory arbiter.
package mem_pkg;

    localparam int LINE_W  = 128;
    localparam int LADDR_W = 28;

    typedef enum logic [2:0] {IDLE, WB, FILL_D, FILL_I, RESP} arb_state_t;

    typedef enum logic {GNT_I, GNT_D} grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: combinational grant, registered record of the last side served.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic req_d,
    input  logic update,
    input  logic upd_d,
    output logic gnt_d
);
    import mem_pkg::*;

    grant_t last_grant;

    // Starting from GNT_I lets the D side win the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GNT_I;
        end else if (update) begin
            last_grant <= upd_d ? GNT_D : GNT_I;
        end
    end

    always_comb begin
        gnt_d = req_d;
        if (req_i && req_d) begin
            gnt_d = (last_grant == GNT_I);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache fills and D-cache writebacks/fills,
// sequencing a D writeback ahead of its refill and routing responses back.
module mem_arbiter #(
    parameter int LINE_W  = mem_pkg::LINE_W,
    parameter int LADDR_W = mem_pkg::LADDR_W,
    parameter int TO_MAX  = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reqI_mem,
    input  logic [LADDR_W-1:0] reqAddrI_mem,
    input  logic               reqD_mem,
    input  logic               reqD_cache_write,
    input  logic               reqD_fill,
    input  logic [LADDR_W-1:0] reqAddrD_mem,
    input  logic [LADDR_W-1:0] reqAddrD_write_mem,
    input  logic [LINE_W-1:0]  data_to_mem,
    output logic [LINE_W-1:0]  data_from_mem_I,
    output logic               read_ready_I,
    output logic [LINE_W-1:0]  data_from_mem_D,
    output logic               read_ready_from_mem,
    output logic               written_data_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic [LADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               mem_timeout
);
    import mem_pkg::*;

    localparam int CNT_W = $clog2(TO_MAX + 1);

    arb_state_t         state, state_n;
    logic               gnt_d;
    logic               any_req;
    logic               lat_d;
    logic               lat_fill;
    logic [LADDR_W-1:0] lat_raddr;
    logic [LADDR_W-1:0] lat_waddr;
    logic [LINE_W-1:0]  lat_wdata;
    logic [CNT_W-1:0]   to_cnt;

    assign any_req = reqI_mem | reqD_mem;

    rr_arb2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req_i  (reqI_mem),
        .req_d  (reqD_mem),
        .update (state == RESP),
        .upd_d  (lat_d),
        .gnt_d  (gnt_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request snapshot taken at grant; the caches may change their inputs afterwards.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            lat_d     <= gnt_d;
            lat_fill  <= gnt_d ? reqD_fill : 1'b1;
            lat_raddr <= gnt_d ? reqAddrD_mem : reqAddrI_mem;
            lat_waddr <= reqAddrD_write_mem;
            lat_wdata <= data_to_mem;
        end
    end

    always_comb begin
        state_n   = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (gnt_d) begin
                        state_n = reqD_cache_write ? WB : FILL_D;
                    end else begin
                        state_n = FILL_I;
                    end
                end
            end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = lat_waddr;
                mem_wdata = lat_wdata;
                if (mem_ack) begin
                    state_n = lat_fill ? FILL_D : RESP;
                end
            end
            FILL_D, FILL_I: begin
                mem_req  = 1'b1;
                mem_addr = lat_raddr;
                if (mem_ack) begin
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_ready_I        <= 1'b0;
            read_ready_from_mem <= 1'b0;
            written_data_ack    <= 1'b0;
            data_from_mem_I     <= '0;
            data_from_mem_D     <= '0;
        end else begin
            read_ready_I        <= (state == FILL_I) && mem_ack;
            read_ready_from_mem <= (state == FILL_D) && mem_ack;
            written_data_ack    <= (state == WB) && mem_ack && !lat_fill;
            if (state == FILL_I && mem_ack) begin
                data_from_mem_I <= mem_rdata;
            end
            if (state == FILL_D && mem_ack) begin
                data_from_mem_D <= mem_rdata;
            end
        end
    end

    // Timeout only flags the stall; the FSM keeps waiting for the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_req && !mem_ack) begin
            if (to_cnt != CNT_W'(TO_MAX)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_cnt == CNT_W'(TO_MAX - 1)) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios for mem_arbiter with hand-computed expectations, sampled on the falling edge.
module tb_mem_arbiter;

    localparam int LINE_W  = 128;
    localparam int LADDR_W = 28;
    localparam int TO_MAX  = 255;

    logic               clk = 1'b0;
    logic               reset;
    logic               reqI_mem;
    logic [LADDR_W-1:0] reqAddrI_mem;
    logic               reqD_mem;
    logic               reqD_cache_write;
    logic               reqD_fill;
    logic [LADDR_W-1:0] reqAddrD_mem;
    logic [LADDR_W-1:0] reqAddrD_write_mem;
    logic [LINE_W-1:0]  data_to_mem;
    logic [LINE_W-1:0]  data_from_mem_I;
    logic               read_ready_I;
    logic [LINE_W-1:0]  data_from_mem_D;
    logic               read_ready_from_mem;
    logic               written_data_ack;
    logic               mem_req;
    logic               mem_we;
    logic [LADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic [LINE_W-1:0]  mem_rdata;
    logic               mem_ack;
    logic               mem_timeout;

    int tests = 0;
    int fails = 0;

    localparam logic [LINE_W-1:0] I_LINE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [LINE_W-1:0] WB_LINE = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [LINE_W-1:0] D_LINE = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_9999;

    mem_arbiter #(.LINE_W(LINE_W), .LADDR_W(LADDR_W), .TO_MAX(TO_MAX)) dut (
        .clk                (clk),
        .reset              (reset),
        .reqI_mem           (reqI_mem),
        .reqAddrI_mem       (reqAddrI_mem),
        .reqD_mem           (reqD_mem),
        .reqD_cache_write   (reqD_cache_write),
        .reqD_fill          (reqD_fill),
        .reqAddrD_mem       (reqAddrD_mem),
        .reqAddrD_write_mem (reqAddrD_write_mem),
        .data_to_mem        (data_to_mem),
        .data_from_mem_I    (data_from_mem_I),
        .read_ready_I       (read_ready_I),
        .data_from_mem_D    (data_from_mem_D),
        .read_ready_from_mem(read_ready_from_mem),
        .written_data_ack   (written_data_ack),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_ack            (mem_ack),
        .mem_timeout        (mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_req(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reqI_mem = 1'b0; reqD_mem = 1'b0; reqD_cache_write = 1'b0; reqD_fill = 1'b0;
        reqAddrI_mem = '0; reqAddrD_mem = '0; reqAddrD_write_mem = '0;
        data_to_mem = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({mem_req, mem_we, read_ready_I, read_ready_from_mem, written_data_ack, mem_timeout} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {mem_req, mem_we, read_ready_I, read_ready_from_mem, written_data_ack, mem_timeout});
        end
        tests++;
        if (mem_addr !== '0 || mem_wdata !== '0 || data_from_mem_I !== '0 || data_from_mem_D !== '0) begin
            fails++;
            $display("FAIL reset_data: addr %h wdata %h dI %h dD %h want all 0",
                     mem_addr, mem_wdata, data_from_mem_I, data_from_mem_D);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_req: got %b want 0", mem_req);
        end
    endtask

    task automatic test_contention();
        bit ok;
        bit exp_d;
        logic [LINE_W-1:0] rd;
        reqI_mem = 1'b1; reqAddrI_mem = 28'h0000200;
        reqD_mem = 1'b1; reqD_cache_write = 1'b0; reqD_fill = 1'b1; reqAddrD_mem = 28'h0000100;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            wait_req(10, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL rr_req_%0d: mem_req never rose", k);
            end
            tests++;
            if (mem_addr !== (exp_d ? 28'h0000100 : 28'h0000200) || mem_we !== 1'b0) begin
                fails++;
                $display("FAIL rr_grant_%0d: addr %h we %b want addr %h we 0",
                         k, mem_addr, mem_we, exp_d ? 28'h0000100 : 28'h0000200);
            end
            rd = LINE_W'(32'hA0 + k);
            mem_rdata = rd;
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            tests++;
            if (read_ready_from_mem !== exp_d || read_ready_I !== !exp_d) begin
                fails++;
                $display("FAIL rr_pulse_%0d: rrD %b rrI %b want rrD %b rrI %b",
                         k, read_ready_from_mem, read_ready_I, exp_d, !exp_d);
            end
            tests++;
            if ((exp_d ? data_from_mem_D : data_from_mem_I) !== rd) begin
                fails++;
                $display("FAIL rr_data_%0d: got %h want %h", k,
                         exp_d ? data_from_mem_D : data_from_mem_I, rd);
            end
        end
        reqI_mem = 1'b0; reqD_mem = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_i_read();
        bit ok;
        reqI_mem = 1'b1; reqAddrI_mem = 28'h0000040;
        wait_req(5, ok);
        tests++;
        if (!ok || mem_we !== 1'b0 || mem_addr !== 28'h0000040) begin
            fails++;
            $display("FAIL iread_req: ok %b we %b addr %h want 1 0 0000040", ok, mem_we, mem_addr);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || read_ready_I !== 1'b0) begin
            fails++;
            $display("FAIL iread_hold: req %b rrI %b want 1 0", mem_req, read_ready_I);
        end
        mem_rdata = I_LINE;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = '0;
        tests++;
        if (read_ready_I !== 1'b1 || data_from_mem_I !== I_LINE || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL iread_resp: rrI %b data %h req %b want 1 %h 0",
                     read_ready_I, data_from_mem_I, mem_req, I_LINE);
        end
        reqI_mem = 1'b0;
        @(negedge clk);
        tests++;
        if (read_ready_I !== 1'b0 || data_from_mem_I !== I_LINE) begin
            fails++;
            $display("FAIL iread_after: rrI %b data %h want 0 %h", read_ready_I, data_from_mem_I, I_LINE);
        end
    endtask

    task automatic test_wb_fill();
        bit ok;
        int wacks = 0;
        int fills = 0;
        reqD_mem = 1'b1; reqD_cache_write = 1'b1; reqD_fill = 1'b1;
        reqAddrD_write_mem = 28'h0001230; reqAddrD_mem = 28'h0004560; data_to_mem = WB_LINE;
        wait_req(5, ok);
        tests++;
        if (!ok || mem_we !== 1'b1 || mem_addr !== 28'h0001230 || mem_wdata !== WB_LINE) begin
            fails++;
            $display("FAIL wbf_wb: ok %b we %b addr %h wdata %h want 1 1 0001230 %h",
                     ok, mem_we, mem_addr, mem_wdata, WB_LINE);
        end
        data_to_mem = '1; reqAddrD_write_mem = 28'h0FFFFFF;
        @(negedge clk);
        tests++;
        if (mem_wdata !== WB_LINE || mem_addr !== 28'h0001230) begin
            fails++;
            $display("FAIL wbf_latched: wdata %h addr %h want %h 0001230", mem_wdata, mem_addr, WB_LINE);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 28'h0004560) begin
            fails++;
            $display("FAIL wbf_fill: req %b we %b addr %h want 1 0 0004560", mem_req, mem_we, mem_addr);
        end
        mem_rdata = D_LINE;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = '0;
        tests++;
        if (read_ready_from_mem !== 1'b1 || data_from_mem_D !== D_LINE) begin
            fails++;
            $display("FAIL wbf_resp: rrD %b data %h want 1 %h", read_ready_from_mem, data_from_mem_D, D_LINE);
        end
        reqD_mem = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fills += int'(read_ready_from_mem);
            wacks += int'(written_data_ack);
            @(negedge clk);
        end
        tests++;
        if (fills !== 1 || wacks !== 0) begin
            fails++;
            $display("FAIL wbf_pulses: fill pulses %0d wb acks %0d want 1 0", fills, wacks);
        end
        tests++;
        if (data_from_mem_I !== I_LINE) begin
            fails++;
            $display("FAIL wbf_i_hold: got %h want %h", data_from_mem_I, I_LINE);
        end
    endtask

    task automatic test_wb_only();
        bit ok;
        int wacks = 0;
        int fills = 0;
        int writes = 0;
        reqD_mem = 1'b1; reqD_cache_write = 1'b1; reqD_fill = 1'b0;
        reqAddrD_write_mem = 28'h0000ABC; data_to_mem = D_LINE;
        wait_req(5, ok);
        tests++;
        if (!ok || mem_we !== 1'b1 || mem_addr !== 28'h0000ABC) begin
            fails++;
            $display("FAIL wbo_req: ok %b we %b addr %h want 1 1 0000ABC", ok, mem_we, mem_addr);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        tests++;
        if (written_data_ack !== 1'b1 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL wbo_ack: wack %b req %b want 1 0", written_data_ack, mem_req);
        end
        reqD_mem = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wacks += int'(written_data_ack);
            fills += int'(read_ready_from_mem) + int'(read_ready_I);
            writes += int'(mem_req);
            @(negedge clk);
        end
        tests++;
        if (wacks !== 1 || fills !== 0 || writes !== 0) begin
            fails++;
            $display("FAIL wbo_pulses: wacks %0d fills %0d extra req cycles %0d want 1 0 0", wacks, fills, writes);
        end
    endtask

    task automatic test_ack_ignored();
        int pulses = 0;
        mem_rdata = '1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) begin
            pulses += int'(read_ready_I) + int'(read_ready_from_mem) + int'(written_data_ack);
            @(negedge clk);
        end
        tests++;
        if (pulses !== 0 || data_from_mem_I !== I_LINE || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL idle_ack: pulses %0d dI %h req %b want 0 %h 0", pulses, data_from_mem_I, mem_req, I_LINE);
        end
        mem_rdata = '0;
    endtask

    task automatic test_timeout();
        bit ok;
        reqI_mem = 1'b1; reqAddrI_mem = 28'h0000300;
        wait_req(5, ok);
        repeat (TO_MAX - 1) @(negedge clk);
        tests++;
        if (!ok || mem_timeout !== 1'b0) begin
            fails++;
            $display("FAIL to_early: ok %b timeout %b want 1 0", ok, mem_timeout);
        end
        @(negedge clk);
        tests++;
        if (mem_timeout !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 28'h0000300) begin
            fails++;
            $display("FAIL to_set: timeout %b req %b addr %h want 1 1 0000300", mem_timeout, mem_req, mem_addr);
        end
        mem_rdata = I_LINE;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        reqI_mem = 1'b0;
        tests++;
        if (read_ready_I !== 1'b1 || mem_timeout !== 1'b1) begin
            fails++;
            $display("FAIL to_complete: rrI %b timeout %b want 1 1", read_ready_I, mem_timeout);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (mem_timeout !== 1'b1) begin
            fails++;
            $display("FAIL to_sticky: got %b want 1", mem_timeout);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int pulses = 0;
        reqD_mem = 1'b1; reqD_cache_write = 1'b0; reqD_fill = 1'b1; reqAddrD_mem = 28'h0004560;
        wait_req(5, ok);
        tests++;
        if (!ok || mem_we !== 1'b0 || mem_addr !== 28'h0004560) begin
            fails++;
            $display("FAIL rmid_fill: ok %b we %b addr %h want 1 0 0004560", ok, mem_we, mem_addr);
        end
        reset = 1'b1;
        reqD_mem = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0 || read_ready_from_mem !== 1'b0 || mem_timeout !== 1'b0) begin
            fails++;
            $display("FAIL rmid_abort: req %b rrD %b timeout %b want 0 0 0", mem_req, read_ready_from_mem, mem_timeout);
        end
        reset = 1'b0;
        reqI_mem = 1'b1; reqAddrI_mem = 28'h0000777;
        wait_req(5, ok);
        tests++;
        if (!ok || mem_addr !== 28'h0000777 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL rmid_new_i: ok %b addr %h we %b want 1 0000777 0", ok, mem_addr, mem_we);
        end
        mem_rdata = WB_LINE;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        reqI_mem = 1'b0;
        pulses = int'(read_ready_from_mem) + int'(written_data_ack);
        tests++;
        if (read_ready_I !== 1'b1 || data_from_mem_I !== WB_LINE || pulses !== 0) begin
            fails++;
            $display("FAIL rmid_i_done: rrI %b data %h other pulses %0d want 1 %h 0",
                     read_ready_I, data_from_mem_I, pulses, WB_LINE);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_i_read();
        test_wb_fill();
        test_wb_only();
        test_ack_ignored();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
